dram_cmd_checker: RTL and testbench

Receive-side model of the DDR4 command interface driven by `dram_cmd`. It tracks per-bank open/closed state and checks every ACT/RD/WR/PRE against the JEDEC-style timing constraints: tRCD, tRP, tRAS, tRRD_S/L and tCCD_S/L. For each legal RD it returns a CL-delayed read-data-valid burst. It sits at the far end of the command bus as a bus-functional responder and checker for HIT, MISS and EMPTY sequences, including same- and different-bank and bank-group cases.

---
 rtl/dram_cmd_if.sv | 10 +
 rtl/dram_cmd_checker.sv | 172 +++++++++++++++++
 tb/tb_dram_cmd_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_cmd_if.sv
// DDR4-style command bus between a controller and the receive-side checker.
interface dram_cmd_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [1:0] bg;
   logic [1:0] ba;

   modport master (output cmd_valid, cmd, bg, ba);
   modport slave  (input  cmd_valid, cmd, bg, ba);
endinterface

// File: rtl/dram_cmd_checker.sv
// Receive-side DDR4 command checker: tracks bank state, enforces ACT/RD/WR/PRE
// timing, and answers each legal RD with a CL-delayed read-data-valid burst.
module dram_cmd_checker #(
   parameter int unsigned TRCD   = 24,
   parameter int unsigned TRP    = 24,
   parameter int unsigned TRAS   = 52,
   parameter int unsigned TRRD_S = 4,
   parameter int unsigned TRRD_L = 6,
   parameter int unsigned TCCD_S = 4,
   parameter int unsigned TCCD_L = 8,
   parameter int unsigned CL     = 24,
   parameter int unsigned BURST  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   dram_cmd_if.slave   cmd_if,
   output logic        err_valid,
   output logic [3:0]  err_code,
   output logic [15:0] err_count,
   output logic [15:0] bank_open,
   output logic        rd_valid,
   output logic [3:0]  rd_bank
);

   localparam int unsigned NB = 16;
   localparam int unsigned NG = 4;
   localparam int unsigned PD = (CL > 1) ? CL - 1 : 1;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ACT = 3'd1;
   localparam logic [2:0] OP_RD  = 3'd2;
   localparam logic [2:0] OP_WR  = 3'd3;
   localparam logic [2:0] OP_PRE = 3'd4;

   localparam logic [7:0] TRCD_8   = 8'(TRCD);
   localparam logic [7:0] TRP_8    = 8'(TRP);
   localparam logic [7:0] TRAS_8   = 8'(TRAS);
   localparam logic [7:0] TRRD_S_8 = 8'(TRRD_S);
   localparam logic [7:0] TRRD_L_8 = 8'(TRRD_L);
   localparam logic [7:0] TCCD_S_8 = 8'(TCCD_S);
   localparam logic [7:0] TCCD_L_8 = 8'(TCCD_L);

   logic [7:0] since_act [NB];
   logic [7:0] since_pre [NB];
   logic [7:0] grp_act   [NG];
   logic [7:0] grp_col   [NG];
   logic [7:0] any_act;
   logic [7:0] any_col;

   logic [3:0] bank_c;
   logic       is_act_c, is_col_c, is_pre_c;
   logic [3:0] code_c;
   logic       acc_c, acc_act_c, acc_pre_c, acc_col_c, acc_rd_c;

   logic [PD-1:0] pipe_v;
   logic [3:0]    pipe_b [PD];
   logic          launch_v_c;
   logic [3:0]    launch_b_c;
   logic [7:0]    beat_cnt;

   function automatic logic [7:0] sat_inc(input logic [7:0] x);
      return (x == 8'hFF) ? x : x + 8'd1;
   endfunction

   // Command decode and first-failing-check classification on pre-edge counters.
   always_comb begin
      bank_c   = {cmd_if.bg, cmd_if.ba};
      is_act_c = (cmd_if.cmd == OP_ACT);
      is_col_c = (cmd_if.cmd == OP_RD) || (cmd_if.cmd == OP_WR);
      is_pre_c = (cmd_if.cmd == OP_PRE);
      code_c   = 4'd0;
      if (cmd_if.cmd_valid) begin
         if (cmd_if.cmd > OP_PRE)                                   code_c = 4'd8;
         else if (is_act_c && bank_open[bank_c])                    code_c = 4'd1;
         else if (is_col_c && !bank_open[bank_c])                   code_c = 4'd2;
         else if (is_col_c && (since_act[bank_c] < TRCD_8))         code_c = 4'd3;
         else if (is_act_c && (since_pre[bank_c] < TRP_8))          code_c = 4'd4;
         else if (is_act_c && ((grp_act[cmd_if.bg] < TRRD_L_8) ||
                               (any_act < TRRD_S_8)))               code_c = 4'd5;
         else if (is_col_c && ((grp_col[cmd_if.bg] < TCCD_L_8) ||
                               (any_col < TCCD_S_8)))               code_c = 4'd6;
         else if (is_pre_c && bank_open[bank_c] &&
                  (since_act[bank_c] < TRAS_8))                     code_c = 4'd7;
      end
      acc_c     = cmd_if.cmd_valid && (code_c == 4'd0) && (cmd_if.cmd != OP_NOP);
      acc_act_c = acc_c && is_act_c;
      acc_pre_c = acc_c && is_pre_c && bank_open[bank_c];
      acc_col_c = acc_c && is_col_c;
      acc_rd_c  = acc_c && (cmd_if.cmd == OP_RD);
   end

   // Elapsed-time counters: load 1 on an accepted event, else saturate upward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NB; i++) begin
            since_act[i] <= 8'hFF;
            since_pre[i] <= 8'hFF;
         end
         for (int unsigned i = 0; i < NG; i++) begin
            grp_act[i] <= 8'hFF;
            grp_col[i] <= 8'hFF;
         end
         any_act <= 8'hFF;
         any_col <= 8'hFF;
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            since_act[i] <= (acc_act_c && bank_c == 4'(i)) ? 8'd1 : sat_inc(since_act[i]);
            since_pre[i] <= (acc_pre_c && bank_c == 4'(i)) ? 8'd1 : sat_inc(since_pre[i]);
         end
         for (int unsigned i = 0; i < NG; i++) begin
            grp_act[i] <= (acc_act_c && cmd_if.bg == 2'(i)) ? 8'd1 : sat_inc(grp_act[i]);
            grp_col[i] <= (acc_col_c && cmd_if.bg == 2'(i)) ? 8'd1 : sat_inc(grp_col[i]);
         end
         any_act <= acc_act_c ? 8'd1 : sat_inc(any_act);
         any_col <= acc_col_c ? 8'd1 : sat_inc(any_col);
      end
   end

   // Bank state and error reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_open <= 16'h0000;
         err_valid <= 1'b0;
         err_code  <= 4'd0;
         err_count <= 16'h0000;
      end else begin
         if (acc_act_c) bank_open[bank_c] <= 1'b1;
         if (acc_pre_c) bank_open[bank_c] <= 1'b0;
         err_valid <= (code_c != 4'd0);
         if (code_c != 4'd0) begin
            err_code <= code_c;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         end
      end
   end

   // Read latency line; the output burst register supplies the final stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         for (int unsigned i = 0; i < PD; i++) pipe_b[i] <= 4'd0;
      end else begin
         pipe_v[0] <= acc_rd_c;
         pipe_b[0] <= bank_c;
         for (int unsigned i = 1; i < PD; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
      end
   end

   assign launch_v_c = (CL > 1) ? pipe_v[PD-1] : acc_rd_c;
   assign launch_b_c = (CL > 1) ? pipe_b[PD-1] : bank_c;

   // Burst generator: holds rd_valid for BURST beats with the owning bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_bank  <= 4'd0;
         beat_cnt <= 8'd0;
      end else if (launch_v_c) begin
         rd_valid <= 1'b1;
         rd_bank  <= launch_b_c;
         beat_cnt <= 8'(BURST - 1);
      end else if (rd_valid && beat_cnt != 8'd0) begin
         beat_cnt <= beat_cnt - 8'd1;
      end else begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dram_cmd_checker.sv
// Self-checking bench for dram_cmd_checker: directed JEDEC-style sequences plus
// randomized traffic against a timestamp-based reference model.
module tb_dram_cmd_checker;

   localparam int TRCD = 24, TRP = 24, TRAS = 52, TRRD_S = 4, TRRD_L = 6;
   localparam int TCCD_S = 4, TCCD_L = 8, CL = 24, BURST = 4;
   localparam int MAXC = 4096;
   localparam int NEVER = -100000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        err_valid;
   logic [3:0]  err_code;
   logic [15:0] err_count;
   logic [15:0] bank_open;
   logic        rd_valid;
   logic [3:0]  rd_bank;

   dram_cmd_if bus ();

   dram_cmd_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_if    (bus),
      .err_valid (err_valid),
      .err_code  (err_code),
      .err_count (err_count),
      .bank_open (bank_open),
      .rd_valid  (rd_valid),
      .rd_bank   (rd_bank)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: absolute event timestamps, expected beats per cycle.
   int          now;
   logic [15:0] m_open;
   int          t_act [16];
   int          t_pre [16];
   int          t_gact [4];
   int          t_gcol [4];
   int          t_aact, t_acol;
   bit          m_errv;
   int          m_code, m_cnt, m_rb;
   bit          e_rv [MAXC];
   int          e_rb [MAXC];

   typedef struct { int t; int c; int g; int b; } cmd_t;
   cmd_t sched [$];

   function automatic int el(input int t);
      return ((now - t) > 255) ? 255 : (now - t);
   endfunction

   function automatic logic [41:0] exp_vec();
      bit rv;
      rv = (now < MAXC) ? e_rv[now] : 1'b0;
      return {m_errv, 4'(m_code), 16'(m_cnt), m_open, rv, 4'(m_rb)};
   endfunction

   function automatic logic [41:0] obs_vec();
      return {err_valid, err_code, err_count, bank_open, rd_valid, rd_bank};
   endfunction

   task automatic model_reset();
      now = 0; m_open = '0; m_errv = 0; m_code = 0; m_cnt = 0; m_rb = 0;
      t_aact = NEVER; t_acol = NEVER;
      for (int i = 0; i < 16; i++) begin t_act[i] = NEVER; t_pre[i] = NEVER; end
      for (int i = 0; i < 4; i++) begin t_gact[i] = NEVER; t_gcol[i] = NEVER; end
      for (int i = 0; i < MAXC; i++) begin e_rv[i] = 0; e_rb[i] = 0; end
   endtask

   task automatic do_reset();
      bus.cmd_valid = 0; bus.cmd = 3'd0; bus.bg = 2'd0; bus.ba = 2'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      sched.delete();
   endtask

   // Drive one command for one edge and advance the model past that edge.
   task automatic tick(input bit v, input int c, input int g, input int b);
      int  k, code;
      bit  act, col, pre;
      k = g * 4 + b;
      act = (c == 1); col = (c == 2 || c == 3); pre = (c == 4);
      code = 0;
      bus.cmd_valid = v; bus.cmd = 3'(c); bus.bg = 2'(g); bus.ba = 2'(b);
      if (v && c != 0) begin
         if (c > 4)                                                   code = 8;
         else if (act && m_open[k])                                   code = 1;
         else if (col && !m_open[k])                                  code = 2;
         else if (col && el(t_act[k]) < TRCD)                         code = 3;
         else if (act && el(t_pre[k]) < TRP)                          code = 4;
         else if (act && (el(t_gact[g]) < TRRD_L || el(t_aact) < TRRD_S)) code = 5;
         else if (col && (el(t_gcol[g]) < TCCD_L || el(t_acol) < TCCD_S)) code = 6;
         else if (pre && m_open[k] && el(t_act[k]) < TRAS)            code = 7;
         if (code == 0) begin
            if (act) begin
               m_open[k] = 1; t_act[k] = now; t_gact[g] = now; t_aact = now;
            end else if (pre && m_open[k]) begin
               m_open[k] = 0; t_pre[k] = now;
            end else if (col) begin
               t_gcol[g] = now; t_acol = now;
               if (c == 2)
                  for (int j = 0; j < BURST; j++)
                     if (now + CL + j < MAXC) begin
                        e_rv[now + CL + j] = 1; e_rb[now + CL + j] = k;
                     end
            end
         end
      end
      m_errv = (code != 0);
      if (code != 0) begin
         m_code = code;
         if (m_cnt < 65535) m_cnt++;
      end
      @(posedge clk);
      #1;
      now++;
      bus.cmd_valid = 0;
      if (now < MAXC && e_rv[now]) m_rb = e_rb[now];
   endtask

   task automatic add(input int t, input int c, input int g, input int b);
      cmd_t e;
      e.t = t; e.c = c; e.g = g; e.b = b;
      sched.push_back(e);
   endtask

   task automatic tick_sched();
      cmd_t e;
      bit   f = 0;
      foreach (sched[i]) if (sched[i].t == now) begin e = sched[i]; f = 1; end
      if (f) tick(1, e.c, e.g, e.b);
      else   tick(0, 0, 0, 0);
   endtask

   task automatic test_reset();
      bus.cmd_valid = 0; bus.cmd = 3'd0; bus.bg = 2'd0; bus.ba = 2'd0;
      rst_n = 1'b0;
      #3;
      n_chk++;
      if (obs_vec() !== 42'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %h want %h", obs_vec(), 42'd0);
      end
      do_reset();
   endtask

   task automatic test_empty();
      do_reset();
      add(0, 1, 0, 0); add(24, 2, 0, 0);
      repeat (60) begin
         tick_sched();
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL empty cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
         if (now >= 47 && now <= 52) begin
            n_chk++;
            if (rd_valid !== (now >= 48 && now <= 51) || rd_bank !== 4'h0 || err_valid !== 1'b0) begin
               n_fail++; $display("FAIL empty_burst cyc %0d: got v=%b bank=%h err=%b", now, rd_valid, rd_bank, err_valid);
            end
         end
      end
      n_chk++;
      if (bank_open !== 16'h0001) begin
         n_fail++; $display("FAIL empty_bank_open: got %h want 0001", bank_open);
      end
   endtask

   task automatic test_trcd();
      do_reset();
      add(0, 1, 0, 0); add(23, 2, 0, 0); add(24, 2, 0, 0);
      repeat (60) begin
         tick_sched();
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL trcd cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
         if (now == 24) begin
            n_chk++;
            if ({err_valid, err_code, err_count} !== {1'b1, 4'd3, 16'd1}) begin
               n_fail++; $display("FAIL trcd_err: got v=%b code=%0d cnt=%0d want 1/3/1", err_valid, err_code, err_count);
            end
         end
         if (now == 47 || now == 48) begin
            n_chk++;
            if (rd_valid !== (now == 48)) begin
               n_fail++; $display("FAIL trcd_retry_burst cyc %0d: got %b", now, rd_valid);
            end
         end
      end
   endtask

   task automatic test_miss();
      do_reset();
      add(0, 1, 0, 0); add(51, 4, 0, 0); add(52, 4, 0, 0); add(75, 1, 0, 0); add(76, 1, 0, 0);
      add(380, 4, 0, 0);
      repeat (385) begin
         tick_sched();
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL miss cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
         if (now == 52 || now == 76) begin
            n_chk++;
            if (err_valid !== 1'b1 || err_code !== ((now == 52) ? 4'd7 : 4'd4)) begin
               n_fail++; $display("FAIL miss_code cyc %0d: got v=%b code=%0d", now, err_valid, err_code);
            end
         end
         if (now == 77 || now == 381) begin
            n_chk++;
            if (err_valid !== 1'b0 || bank_open !== ((now == 77) ? 16'h0001 : 16'h0000)) begin
               n_fail++; $display("FAIL miss_accept cyc %0d: got err=%b open=%h", now, err_valid, bank_open);
            end
         end
      end
   endtask

   task automatic test_bank_group();
      do_reset();
      add(0, 1, 0, 0); add(5, 1, 0, 1); add(6, 1, 0, 1); add(10, 1, 1, 0);
      add(16, 1, 1, 1); add(18, 1, 2, 0);
      add(40, 2, 0, 0); add(44, 2, 1, 0); add(48, 2, 1, 1); add(52, 2, 1, 1); add(54, 2, 0, 0);
      repeat (90) begin
         tick_sched();
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL bank_group cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
         if (now == 6 || now == 19 || now == 49 || now == 55) begin
            n_chk++;
            if (err_valid !== 1'b1 || err_code !== ((now < 40) ? 4'd5 : 4'd6)) begin
               n_fail++; $display("FAIL bg_spacing cyc %0d: got v=%b code=%0d", now, err_valid, err_code);
            end
         end
         if (now == 7 || now == 11 || now == 17 || now == 53) begin
            n_chk++;
            if (err_valid !== 1'b0) begin
               n_fail++; $display("FAIL bg_accept cyc %0d: got err_valid=%b want 0", now, err_valid);
            end
         end
      end
   endtask

   task automatic test_state_errors();
      do_reset();
      add(0, 1, 0, 0); add(30, 1, 0, 0); add(40, 2, 1, 2); add(41, 6, 0, 0);
      add(42, 4, 3, 3); add(44, 7, 2, 1); add(45, 5, 0, 0); add(50, 3, 0, 0);
      repeat (90) begin
         tick_sched();
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL state cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
         if (now == 31 || now == 41 || now == 42) begin
            n_chk++;
            if (err_valid !== 1'b1 || err_code !== ((now == 31) ? 4'd1 : (now == 41) ? 4'd2 : 4'd8)) begin
               n_fail++; $display("FAIL state_code cyc %0d: got v=%b code=%0d", now, err_valid, err_code);
            end
         end
         if (now == 43) begin
            n_chk++;
            if ({err_valid, err_code, err_count} !== {1'b0, 4'd8, 16'd3}) begin
               n_fail++; $display("FAIL pre_closed: got v=%b code=%0d cnt=%0d want 0/8/3", err_valid, err_code, err_count);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      add(0, 1, 0, 0); add(24, 2, 0, 0);
      repeat (49) tick_sched();
      n_chk++;
      if (rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_burst: got rd_valid=%b want 1", rd_valid);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({rd_valid, bank_open, err_count} !== 33'd0) begin
         n_fail++; $display("FAIL async_reset: got v=%b open=%h cnt=%0d want 0", rd_valid, bank_open, err_count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      sched.delete();
      add(2, 2, 0, 0);
      repeat (40) begin
         tick_sched();
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL post_reset cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
         if (now == 3) begin
            n_chk++;
            if (err_valid !== 1'b1 || err_code !== 4'd2) begin
               n_fail++; $display("FAIL post_reset_code: got v=%b code=%0d want 1/2", err_valid, err_code);
            end
         end
      end
   endtask

   task automatic test_random();
      int r, c;
      do_reset();
      repeat (1800) begin
         r = int'($urandom_range(0, 15));
         if (r < 6)       c = 0;
         else if (r < 9)  c = 1;
         else if (r < 12) c = 2;
         else if (r < 13) c = 3;
         else if (r < 15) c = 4;
         else             c = int'($urandom_range(5, 7));
         tick((c != 0) || ($urandom_range(0, 1) == 1), c,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
         n_chk++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL random cyc %0d: got %h want %h", now, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_empty();
      test_trcd();
      test_miss();
      test_bank_group();
      test_state_errors();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
